fu_cdb_scheduler: RTL and testbench
===================================

Name: fu_cdb_scheduler

Overview:
- Tracks occupancy of the six functional units fed by the reservation station: ALU_1, ALU_2, ALU_3, MULT_1, MULT_2 and BRANCH.
- Sequences each unit through execute latency and arbitrates completed results onto the CDB slots.
- Drives the per-FU busy bits that the RS issue selector consumes.
- Drives the CDB tags that the RS wakeup logic compares against.

Parameters:
- N_FU, 6: number of FUs. Index 0-2 ALU_1..3, 3-4 MULT_1..2, 5 BRANCH (fixed mapping).
- CDB_W, 3: CDB slots per cycle (equals SUPERSCALAR_WAYS).
- PR_W, 6: physical-register tag width.
- ALU_LAT, 1: ALU latency in cycles (>=1).
- MULT_LAT, 4: MULT latency in cycles (>=1).
- BR_LAT, 1: BRANCH latency in cycles (>=1).

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high
- flush  in  1  squash all in-flight FU work
- issue_valid  in  N_FU  per-FU issue strobe from RS this cycle
- issue_tag  in  N_FU*PR_W  destination tag per FU issue
- fu_busy  out  N_FU  1 = FU cannot accept an issue this cycle
- cdb_valid  out  CDB_W  slot carries a result
- cdb_tag  out  CDB_W*PR_W  broadcast tag; 0 when slot invalid
- cdb_fu_idx  out  CDB_W*3  index of the FU granted to the slot
- protocol_err  out  1  sticky; set on issue to a busy FU

Behaviour:
- Reset: reset is synchronous, active-high, on clock.
  - All FU states go to IDLE; counters 0; tags 0; rr_ptr 0; protocol_err 0.
  - Outputs during and after reset: fu_busy 0, cdb_valid 0, cdb_tag 0, cdb_fu_idx 0.
- Per-FU FSM has three states: IDLE, EXEC, DONE. Each FU holds a tag register and a down-counter of clog2(MULT_LAT+1) bits.
- IDLE:
  - Accept when issue_valid[i] is high and fu_busy[i] is low: latch the tag.
  - Then go to DONE if LAT==1, else go to EXEC with cnt=LAT-1.
- EXEC: cnt decrements each cycle. When cnt==1, go to DONE at the next edge.
- Latency rule: issue in cycle c puts the FU in DONE in cycle c+LAT, which is its earliest CDB cycle.
- DONE:
  - FU is a CDB requester.
  - If granted this cycle: go to IDLE, or accept a same-cycle issue and restart (back-to-back).
  - If not granted: hold DONE and tag.
- Busy definition: fu_busy[i] = EXEC or (DONE and not granted this cycle). It is combinational through the grant.
  - IDLE is never busy.
  - An ALU granted every cycle sustains 1 issue per cycle.
- Issue to a busy FU is ignored (state unchanged) and sets protocol_err. protocol_err clears only on reset.
- CDB arbitration (combinational):
  - Scan FUs starting at rr_ptr, ascending, wrapping mod N_FU.
  - Grant the first up to CDB_W units in DONE.
  - The k-th grant goes to slot k; slots fill from 0 with no gaps.
  - Unused slots: valid 0, tag 0, fu_idx 0.
- Fairness: if any grant occurs, rr_ptr_next = (last granted index + 1) mod N_FU. Otherwise rr_ptr holds.
- Flush:
  - In the flush cycle, cdb_valid is forced 0 and all issues are ignored; protocol_err is not set.
  - At the next edge, all FUs go to IDLE and rr_ptr resets to 0.
  - fu_busy is still computed normally in the flush cycle.
- Reset has priority over flush. Reset mid-EXEC drops the result: no CDB output for it.
- Tag 0 is reserved as "none"; issue_tag 0 is legal but broadcasts as 0.
- The RS treats tag 0 as always-matched, so cdb_tag must be 0 on every invalid slot.

Test Plan:
- ALU latency: issue ALU_1 tag 5 in cycle 1 -> cycle 2 cdb_valid=001, slot0 tag 5, fu_idx 0; fu_busy[0]=0 in cycle 2.
- MULT latency: issue MULT_1 tag 9 in cycle 1 -> fu_busy[3]=1 in cycles 2-4; CDB slot0 tag 9 in cycle 5 only.
- Contention: all six FUs in DONE with tags 1..6, rr_ptr=0 -> cycle A grants FUs 0,1,2 (tags 1,2,3), rr_ptr=3; cycle B grants 3,4,5; fu_busy[3..5]=1 during cycle A.
- Round-robin wrap: rr_ptr=4, DONE on FUs 0,1,5 -> slot order FU5, FU0, FU1; rr_ptr_next=2.
- Busy issue: issue MULT_1 while in EXEC -> no state change, protocol_err=1 and stays 1 until reset.
- Flush/reset: flush while MULT_2 in EXEC and ALU_2 in DONE -> that cycle cdb_valid=000; next cycle all fu_busy=0 and no later CDB output. Repeat with reset -> same result, protocol_err=0.

Source files
------------

// File: rtl/fu_cdb_scheduler.sv
// Functional-unit occupancy tracker and round-robin CDB arbiter for the six
// RS-fed units (3 ALU, 2 MULT, 1 BRANCH).
module fu_cdb_scheduler #(
   parameter int N_FU     = 6,
   parameter int CDB_W    = 3,
   parameter int PR_W     = 6,
   parameter int ALU_LAT  = 1,
   parameter int MULT_LAT = 4,
   parameter int BR_LAT   = 1
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    flush,
   input  logic [N_FU-1:0]         issue_valid,
   input  logic [N_FU*PR_W-1:0]    issue_tag,
   output logic [N_FU-1:0]         fu_busy,
   output logic [CDB_W-1:0]        cdb_valid,
   output logic [CDB_W*PR_W-1:0]   cdb_tag,
   output logic [CDB_W*3-1:0]      cdb_fu_idx,
   output logic                    protocol_err
);

   localparam int IDX_W   = 3;
   localparam int SLOT_W  = (CDB_W > 1) ? $clog2(CDB_W) : 1;
   localparam int MAX_LAT = (MULT_LAT >= ALU_LAT && MULT_LAT >= BR_LAT) ? MULT_LAT :
                            (ALU_LAT >= BR_LAT) ? ALU_LAT : BR_LAT;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   function automatic int fu_lat(input int i);
      if (i < 3)      return ALU_LAT;
      else if (i < 5) return MULT_LAT;
      else            return BR_LAT;
   endfunction

   logic [1:0]       state  [N_FU];
   logic [CNT_W-1:0] cnt    [N_FU];
   logic [PR_W-1:0]  tag_q  [N_FU];
   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] rr_next;

   logic [N_FU-1:0]  granted;
   logic [N_FU-1:0]  busy_int;
   logic [CDB_W-1:0] slot_vld;
   logic [IDX_W-1:0] slot_fu [CDB_W];

   // Rotating scan from rr_ptr; the k-th DONE unit found lands in slot k.
   always_comb begin
      int idx;
      int n_grant;
      logic [IDX_W-1:0] last_idx;
      granted  = '0;
      slot_vld = '0;
      for (int s = 0; s < CDB_W; s++) slot_fu[s] = '0;
      n_grant  = 0;
      last_idx = rr_ptr;
      idx      = 0;
      for (int k = 0; k < N_FU; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= N_FU) idx = idx - N_FU;
         if (state[IDX_W'(idx)] == ST_DONE && n_grant < CDB_W) begin
            granted[IDX_W'(idx)]       = 1'b1;
            slot_vld[SLOT_W'(n_grant)] = 1'b1;
            slot_fu[SLOT_W'(n_grant)]  = IDX_W'(idx);
            last_idx                   = IDX_W'(idx);
            n_grant                    = n_grant + 1;
         end
      end
      if (n_grant == 0)                       rr_next = rr_ptr;
      else if (last_idx == IDX_W'(N_FU - 1))  rr_next = '0;
      else                                    rr_next = last_idx + 1'b1;
   end

   // Busy passes combinationally through the grant so a granted unit can take
   // a back-to-back issue in the same cycle.
   always_comb begin
      for (int i = 0; i < N_FU; i++)
         busy_int[i] = (state[i] == ST_EXEC) || (state[i] == ST_DONE && !granted[i]);
      fu_busy = reset ? '0 : busy_int;
   end

   // Invalid slots must broadcast tag 0: the RS treats tag 0 as always-matched.
   always_comb begin
      logic v;
      cdb_valid  = '0;
      cdb_tag    = '0;
      cdb_fu_idx = '0;
      for (int s = 0; s < CDB_W; s++) begin
         v = slot_vld[s] && !flush && !reset;
         cdb_valid[s] = v;
         if (v) begin
            cdb_tag[s*PR_W +: PR_W] = tag_q[slot_fu[s]];
            cdb_fu_idx[s*3 +: 3]    = slot_fu[s];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rr_ptr       <= '0;
         protocol_err <= 1'b0;
         for (int i = 0; i < N_FU; i++) begin
            state[i] <= ST_IDLE;
            cnt[i]   <= '0;
            tag_q[i] <= '0;
         end
      end else if (flush) begin
         rr_ptr <= '0;
         for (int i = 0; i < N_FU; i++) begin
            state[i] <= ST_IDLE;
            cnt[i]   <= '0;
         end
      end else begin
         rr_ptr <= rr_next;
         if (|(issue_valid & busy_int)) protocol_err <= 1'b1;
         for (int i = 0; i < N_FU; i++) begin
            if (issue_valid[i] && !busy_int[i]) begin
               tag_q[i] <= issue_tag[i*PR_W +: PR_W];
               if (fu_lat(i) == 1) begin
                  state[i] <= ST_DONE;
               end else begin
                  state[i] <= ST_EXEC;
                  cnt[i]   <= CNT_W'(fu_lat(i) - 1);
               end
            end else if (state[i] == ST_DONE && granted[i]) begin
               state[i] <= ST_IDLE;
            end else if (state[i] == ST_EXEC) begin
               cnt[i] <= cnt[i] - 1'b1;
               if (cnt[i] == CNT_W'(1)) state[i] <= ST_DONE;
            end
         end
      end
   end

endmodule

// File: tb/tb_fu_cdb_scheduler.sv
// Scoreboard bench for fu_cdb_scheduler: directed scenarios plus randomized
// traffic, checked against a remaining-cycles model of each functional unit.
module tb_fu_cdb_scheduler;

   localparam int N_FU  = 6;
   localparam int CDB_W = 3;
   localparam int PR_W  = 6;

   logic                  clock = 1'b0;
   logic                  reset = 1'b1;
   logic                  flush = 1'b0;
   logic [N_FU-1:0]       issue_valid = '0;
   logic [N_FU*PR_W-1:0]  issue_tag = '0;
   logic [N_FU-1:0]       fu_busy;
   logic [CDB_W-1:0]      cdb_valid;
   logic [CDB_W*PR_W-1:0] cdb_tag;
   logic [CDB_W*3-1:0]    cdb_fu_idx;
   logic                  protocol_err;

   fu_cdb_scheduler dut (
      .clock(clock), .reset(reset), .flush(flush),
      .issue_valid(issue_valid), .issue_tag(issue_tag),
      .fu_busy(fu_busy), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
      .cdb_fu_idx(cdb_fu_idx), .protocol_err(protocol_err)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [N_FU-1:0]       busy;
      logic [CDB_W-1:0]      vld;
      logic [CDB_W*PR_W-1:0] tag;
      logic [CDB_W*3-1:0]    idx;
      logic                  perr;
   } exp_t;

   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;

   // Model: an occupied unit has m_rem cycles left before it can broadcast.
   bit              m_occ [N_FU];
   int              m_rem [N_FU];
   logic [PR_W-1:0] m_tag [N_FU];
   int              m_ptr = 0;
   bit              m_perr = 0;

   function automatic int lat(input int i);
      if (i < 3) return 1;
      else if (i < 5) return 4;
      else return 1;
   endfunction

   function automatic void arb(output logic [N_FU-1:0] g, output int ord[CDB_W], output int ng);
      g = '0; ng = 0;
      for (int s = 0; s < CDB_W; s++) ord[s] = 0;
      for (int k = 0; k < N_FU; k++) begin
         int f;
         f = (m_ptr + k) % N_FU;
         if (m_occ[f] && m_rem[f] == 0 && ng < CDB_W) begin
            g[f] = 1'b1; ord[ng] = f; ng++;
         end
      end
   endfunction

   function automatic logic [N_FU-1:0] model_busy();
      logic [N_FU-1:0] g, b;
      int ord[CDB_W];
      int ng;
      arb(g, ord, ng);
      for (int i = 0; i < N_FU; i++) b[i] = m_occ[i] && (m_rem[i] > 0 || !g[i]);
      return b;
   endfunction

   task automatic step(input bit rst, input bit fl, input logic [N_FU-1:0] iv,
                       input logic [N_FU*PR_W-1:0] tags);
      logic [N_FU-1:0] g;
      int ord[CDB_W];
      int ng;
      exp_t e;
      @(posedge clock);
      #1;
      reset = rst; flush = fl; issue_valid = iv; issue_tag = tags;
      cyc++;
      arb(g, ord, ng);
      e = '0;
      e.perr = m_perr;
      if (!rst) begin
         for (int i = 0; i < N_FU; i++) e.busy[i] = m_occ[i] && (m_rem[i] > 0 || !g[i]);
         if (!fl)
            for (int s = 0; s < ng; s++) begin
               e.vld[s] = 1'b1;
               e.tag[s*PR_W +: PR_W] = m_tag[ord[s]];
               e.idx[s*3 +: 3] = 3'(ord[s]);
            end
      end
      exp_q.push_back(e);
      if (rst) begin
         for (int i = 0; i < N_FU; i++) begin m_occ[i] = 0; m_rem[i] = 0; m_tag[i] = '0; end
         m_ptr = 0; m_perr = 0;
      end else if (fl) begin
         for (int i = 0; i < N_FU; i++) m_occ[i] = 0;
         m_ptr = 0;
      end else begin
         if (ng > 0) m_ptr = (ord[ng-1] + 1) % N_FU;
         for (int i = 0; i < N_FU; i++) begin
            if (g[i]) m_occ[i] = 0;
            else if (m_occ[i] && m_rem[i] > 0) m_rem[i]--;
            if (iv[i]) begin
               if (e.busy[i]) m_perr = 1;
               else begin
                  m_occ[i] = 1; m_rem[i] = lat(i) - 1; m_tag[i] = tags[i*PR_W +: PR_W];
               end
            end
         end
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, 0, '0, '0);
   endtask

   function automatic logic [N_FU*PR_W-1:0] one_tag(input int f, input int t);
      logic [N_FU*PR_W-1:0] v;
      v = '0;
      v[f*PR_W +: PR_W] = PR_W'(t);
      return v;
   endfunction

   // Monitor samples combinational outputs mid-cycle, away from the edge.
   always @(negedge clock) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         bit bad;
         e = exp_q.pop_front();
         bad = 0;
         vectors++;
         if (fu_busy !== e.busy) begin
            bad = 1; $display("FAIL fu_busy cycle %0d: got %b expected %b", cyc, fu_busy, e.busy);
         end
         if (cdb_valid !== e.vld) begin
            bad = 1; $display("FAIL cdb_valid cycle %0d: got %b expected %b", cyc, cdb_valid, e.vld);
         end
         if (cdb_tag !== e.tag) begin
            bad = 1; $display("FAIL cdb_tag cycle %0d: got %h expected %h", cyc, cdb_tag, e.tag);
         end
         if (cdb_fu_idx !== e.idx) begin
            bad = 1; $display("FAIL cdb_fu_idx cycle %0d: got %h expected %h", cyc, cdb_fu_idx, e.idx);
         end
         if (protocol_err !== e.perr) begin
            bad = 1; $display("FAIL protocol_err cycle %0d: got %b expected %b", cyc, protocol_err, e.perr);
         end
         if (bad) miscompares++;
      end
   end

   initial begin
      for (int i = 0; i < N_FU; i++) begin m_occ[i] = 0; m_rem[i] = 0; m_tag[i] = '0; end
      step(1, 0, '0, '0);
      step(1, 0, '0, '0);
      idle(1);
      // ALU_1 latency
      step(0, 0, 6'b000001, one_tag(0, 5));
      idle(2);
      // MULT_1 latency
      step(0, 0, 6'b001000, one_tag(3, 9));
      idle(6);
      // full contention from rr_ptr 0
      step(0, 1, '0, '0);
      step(0, 0, 6'b011000, one_tag(3, 4) | one_tag(4, 5));
      idle(2);
      step(0, 0, 6'b100111, one_tag(0, 1) | one_tag(1, 2) | one_tag(2, 3) | one_tag(5, 6));
      idle(3);
      // wrap: rr_ptr lands on 4 with FUs 0,1,5 pending
      step(0, 0, 6'b001000, one_tag(3, 7));
      idle(3);
      step(0, 0, 6'b100011, one_tag(0, 11) | one_tag(1, 12) | one_tag(5, 13));
      idle(2);
      // back-to-back ALU issue while granted
      for (int k = 0; k < 4; k++) step(0, 0, 6'b000001, one_tag(0, 20 + k));
      idle(1);
      // flush with MULT_2 in EXEC and ALU_2 in DONE
      step(0, 0, 6'b010000, one_tag(4, 30));
      step(0, 0, 6'b000010, one_tag(1, 31));
      step(0, 1, 6'b000100, one_tag(2, 32));
      idle(6);
      // issue to a busy MULT sets sticky error
      step(0, 0, 6'b001000, one_tag(3, 40));
      step(0, 0, 6'b001000, one_tag(3, 41));
      idle(6);
      // same scenario terminated by reset
      step(0, 0, 6'b010000, one_tag(4, 50));
      step(0, 0, 6'b000010, one_tag(1, 51));
      step(1, 0, 6'b000100, one_tag(2, 52));
      idle(6);
      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         logic [N_FU-1:0] mb, iv;
         logic [N_FU*PR_W-1:0] tags;
         bit rst, fl;
         mb = model_busy();
         rst = ($urandom_range(0, 199) == 0);
         fl  = ($urandom_range(0, 39) == 0);
         iv  = '0;
         for (int i = 0; i < N_FU; i++)
            if ($urandom_range(0, 2) == 0 && (!mb[i] || $urandom_range(0, 29) == 0)) iv[i] = 1'b1;
         tags = {$urandom(), $urandom()};
         step(rst, fl, iv, tags);
      end
      idle(2);
      repeat (3) @(negedge clock);
      if (exp_q.size() != 0) begin
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
         miscompares++;
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
